// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle execute-stage ALU.
//   - ALU_* : 4-bit operation codes produced by the ALU control unit.
//   - alu_state_e : ALU sequencer state encoding, also used by the ALU control
//     unit and the pipeline control FSM.
package alu_pkg;

  localparam logic [3:0] ALU_MOVI = 4'b0000;
  localparam logic [3:0] ALU_MOV  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the pipeline control and the multicycle ALU.
//   start, alu_control, a, b     : request side (driven by master)
//   busy, done                   : handshake status (driven by slave)
//   result_lo, result_hi         : 2*WIDTH result, hi:lo
//   zero, div_by_zero, illegal_op: status flags registered with the result
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output start, alu_control, a, b,
    input  busy, done, result_lo, result_hi, zero, div_by_zero, illegal_op
  );

  modport slave (
    input  start, alu_control, a, b,
    output busy, done, result_lo, result_hi, zero, div_by_zero, illegal_op
  );

endinterface

// File: rtl/alu_iter_div.sv
// Unsigned restoring divider, one quotient bit per cycle over WIDTH cycles.
//   clk, rst_n     : clock, asynchronous active-low reset (aborts a division)
//   start_i        : load dividend_i/divisor_i and begin; divisor must be non-zero
//   done_o         : high during the final iteration
//   quotient_o     : quotient produced by the current iteration
//   remainder_o    : remainder produced by the current iteration
// quotient_o/remainder_o are the combinational outputs of the iteration in
// progress, so while done_o is high they carry the final result and the caller
// can register them on the same edge that ends the division.
module alu_iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic             busy_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and a kept difference fits back in WIDTH bits.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign fits   = ~trial[WIDTH];
  assign rem_d  = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_d  = {quo_q[WIDTH-2:0], fits};

  assign done_o      = busy_q && (cnt_q == WIDTH'(WIDTH - 1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q + WIDTH'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with a start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any operation)
//   bus        : multicycle_alu_if slave port (request, handshake, result, flags)
// MOVI/MOV/ADD/SUB, DIV by zero and illegal codes finish one cycle after start.
// MULT (inline shift-add) and DIV (alu_iter_div) take WIDTH iterations.
// Results and flags change only on entry to DONE and hold until the next one.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_alu_if.slave     bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             zero_q, zero_d, dbz_q, dbz_d, ill_q, ill_d;
  logic             res_we;

  logic             accept, mul_last, div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic             busy, done;

  // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
  assign accept    = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign div_start = accept && (bus.alu_control == ALU_DIV) && (bus.b != '0);
  assign mul_last  = (state_q == ST_MUL) && (cnt_q == WIDTH'(WIDTH - 1));

  // Shift-add step: acc holds {partial product, unconsumed multiplier bits};
  // add the multiplicand into the upper half when the current bit is set,
  // then shift the whole accumulator right, keeping the carry.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{acc_q[0]}}};
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

  alu_iter_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (bus.a),
    .divisor_i   (bus.b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (bus.alu_control == ALU_MULT) state_d = ST_MUL;
          else if (div_start)              state_d = ST_DIV;
          else                             state_d = ST_DONE;
        end
      end
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    done = (state_q == ST_DONE);
  end

  // Result selection; written only on the edge that enters DONE.
  always_comb begin
    res_we = 1'b0;
    lo_d   = lo_q;
    hi_d   = hi_q;
    dbz_d  = dbz_q;
    ill_d  = ill_q;
    if (accept && bus.alu_control != ALU_MULT && !div_start) begin
      res_we = 1'b1;
      hi_d   = '0;
      dbz_d  = 1'b0;
      ill_d  = 1'b0;
      case (bus.alu_control)
        ALU_MOVI: lo_d = bus.b;
        ALU_MOV:  lo_d = bus.a;
        ALU_ADD:  lo_d = bus.a + bus.b;
        ALU_SUB:  lo_d = bus.a - bus.b;
        ALU_DIV: begin
          lo_d  = '1;
          hi_d  = bus.a;
          dbz_d = 1'b1;
        end
        default: begin
          lo_d  = '0;
          ill_d = 1'b1;
        end
      endcase
    end else if (mul_last) begin
      res_we       = 1'b1;
      {hi_d, lo_d} = acc_step;
      dbz_d        = 1'b0;
      ill_d        = 1'b0;
    end else if (state_q == ST_DIV && div_done) begin
      res_we = 1'b1;
      lo_d   = div_quo;
      hi_d   = div_rem;
      dbz_d  = 1'b0;
      ill_d  = 1'b0;
    end
    zero_d = res_we ? (lo_d == '0) : zero_q;
  end

  // Multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (accept && bus.alu_control == ALU_MULT) begin
      cnt_q   <= '0;
      mcand_q <= bus.a;
      acc_q   <= {{WIDTH{1'b0}}, bus.b};
    end else if (state_q == ST_MUL) begin
      cnt_q   <= cnt_q + WIDTH'(1);
      acc_q   <= acc_step;
    end
  end

  // Result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      zero_q <= zero_d;
      dbz_q  <= dbz_d;
      ill_q  <= ill_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;

endmodule
